ram_2_16x32: RTL and testbench



---
 rtl/ram_2_16x32.sv | 59 +++++
 tb/tb_ram_2_16x32.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ram_2_16x32.sv
// ----------------------------------------------------------------------------
// ram_2_16x32
// Single-port synchronous data memory, 2^ADDR_WIDTH words x DATA_WIDTH bits.
// One shared word address serves a write port and a registered read port,
// each with its own enable. Everything happens on the rising edge of clk.
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous active-high reset (clears data_output only)
//   write_enable  in   write data_input to mem[address] at the edge
//   read_enable   in   load data_output from mem[address] at the edge
//   address       in   word address shared by read and write
//   data_input    in   write data
//   data_output   out  registered read data, held between enabled reads
// ----------------------------------------------------------------------------
module ram_2_16x32 #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_input,
    output logic [DATA_WIDTH-1:0] data_output
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Contents start at zero through the declaration initialiser; reset
    // deliberately leaves the array alone so data survives a CPU reset.
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1] = '{default: '0};
    logic [DATA_WIDTH-1:0] r_dout;

    // Storage array: no reset term so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && write_enable) begin
            r_mem[address] <= data_input;
        end
    end

    // Read register. A read colliding with a write to the same (only)
    // address returns the new data: write-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (read_enable) begin
            if (write_enable) begin
                r_dout <= data_input;
            end else begin
                r_dout <= r_mem[address];
            end
        end
    end

    assign data_output = r_dout;

endmodule

// File: tb/tb_ram_2_16x32.sv
module tb_ram_2_16x32;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_enable;
    logic        read_enable;
    logic [15:0] address;
    logic [31:0] data_input;
    logic [31:0] data_output;

    ram_2_16x32 dut (
        .clk          (clk),
        .rst          (rst),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .address      (address),
        .data_input   (data_input),
        .data_output  (data_output)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    bit   done   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: after each edge, compare every expectation stamped for it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.cyc != cyc) begin
                    errors++;
                    $display("FAIL %s: check missed (stamped cycle %0d, now %0d)", e.name, e.cyc, cyc);
                end else if (data_output !== e.exp) begin
                    errors++;
                    $display("FAIL %s: data_output=%h expected=%h", e.name, data_output, e.exp);
                end
            end
        end
    end

    // Drive one cycle of inputs; if chk, expect data_output after the next edge.
    task automatic step(input logic r, input logic we, input logic re,
                        input logic [15:0] a, input logic [31:0] d,
                        input bit chk, input logic [31:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        #1;
        rst          = r;
        write_enable = we;
        read_enable  = re;
        address      = a;
        data_input   = d;
        if (chk) begin
            e.cyc  = cyc + 1;
            e.exp  = exp;
            e.name = name;
            q.push_back(e);
        end
    endtask

    initial begin
        rst = 1'b1; write_enable = 1'b0; read_enable = 1'b0;
        address = '0; data_input = '0;

        // Reset, basic write/read
        step(1, 0, 0, 16'd0,  32'd0,  1, 32'd0,  "reset_c1");
        step(1, 0, 0, 16'd0,  32'd0,  1, 32'd0,  "reset_c2");
        step(0, 1, 0, 16'd66, 32'd20, 1, 32'd0,  "write66_no_read");
        step(0, 0, 1, 16'd66, 32'd0,  1, 32'd20, "read66");

        // Write-first collision
        step(0, 1, 1, 16'd55, 32'd1,  1, 32'd1,  "collision55");
        step(0, 0, 1, 16'd55, 32'd0,  1, 32'd1,  "reread55");
        step(0, 0, 1, 16'd66, 32'd0,  1, 32'd20, "reread66");

        // Hold
        step(0, 1, 0, 16'd66, 32'hDEADBEEF, 1, 32'd20, "hold_on_write");
        step(0, 0, 0, 16'd66, 32'd0,        1, 32'd20, "hold_idle");
        step(0, 0, 1, 16'd66, 32'd0,        1, 32'hDEADBEEF, "read66_new");

        // Address boundaries
        step(0, 1, 0, 16'd0,     32'h00000001, 1, 32'hDEADBEEF, "write_addr0");
        step(0, 1, 0, 16'hFFFF,  32'hFFFFFFFF, 1, 32'hDEADBEEF, "write_addr65535");
        step(0, 0, 1, 16'd0,     32'd0, 1, 32'h00000001, "read_addr0");
        step(0, 0, 1, 16'hFFFF,  32'd0, 1, 32'hFFFFFFFF, "read_addr65535");
        step(0, 0, 1, 16'd1,     32'd0, 1, 32'd0,        "read_addr1");
        step(0, 0, 1, 16'hFFFE,  32'd0, 1, 32'd0,        "read_addr65534");

        // Reset mid-operation
        step(0, 0, 1, 16'd66, 32'd0,      1, 32'hDEADBEEF, "pre_reset_read66");
        step(1, 1, 1, 16'd10, 32'h1234,   1, 32'd0, "reset_drops_ops");
        step(0, 0, 0, 16'd10, 32'd0,      1, 32'd0, "post_reset_hold0");
        step(0, 0, 1, 16'd10, 32'd0,      1, 32'd0, "read10_unwritten");
        step(0, 0, 1, 16'd66, 32'd0,      1, 32'hDEADBEEF, "read66_survives");

        // Back-to-back
        step(0, 1, 0, 16'd100, 32'd1, 0, 32'd0, "");
        step(0, 1, 0, 16'd101, 32'd2, 0, 32'd0, "");
        step(0, 1, 0, 16'd102, 32'd3, 0, 32'd0, "");
        step(0, 1, 0, 16'd103, 32'd4, 1, 32'hDEADBEEF, "b2b_write_hold");
        step(0, 0, 1, 16'd100, 32'd0, 1, 32'd1, "b2b_read100");
        step(0, 0, 1, 16'd101, 32'd0, 1, 32'd2, "b2b_read101");
        step(0, 0, 1, 16'd102, 32'd0, 1, 32'd3, "b2b_read102");
        step(0, 0, 1, 16'd103, 32'd0, 1, 32'd4, "b2b_read103");
        step(0, 0, 0, 16'd0,   32'd0, 1, 32'd4, "final_hold");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: timeout, expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule
